// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate producing a saturated Q4.4 pre-activation z = sum(x*w) + b.
// Define NEURON_MAC_ROUND_EN for round-half-up rescaling; the default build truncates toward -inf.
module neuron_mac #(
    parameter int N_INPUTS = 2,
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int ACC_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     z_valid,
    input  logic                     z_ready,
    output logic signed [DATA_W-1:0] z_value
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;
`ifdef NEURON_MAC_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (FRAC_W - 1);
`endif

    typedef enum logic [1:0] {IDLE, ACC, FINAL, OUT} state_t;

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic        [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [DATA_W-1:0]   bias_q, bias_d;
    logic                       in_ready_q, in_ready_d;
    logic                       z_valid_q, z_valid_d;
    logic signed [DATA_W-1:0]   z_value_q, z_value_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    scaled;
    logic signed [DATA_W-1:0]   sat;
    logic                       accept;

    assign accept   = in_valid && in_ready_q;
    assign prod     = x_data * w_data;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - DATA_W){bias_q[DATA_W-1]}}, bias_q};

    // Align the Q4.4 bias to the Q8.8 accumulator, then drop back to Q4.4 and clamp.
    always_comb begin
`ifdef NEURON_MAC_ROUND_EN
        sum = acc_q + (bias_ext <<< FRAC_W) + HALF_LSB;
`else
        sum = acc_q + (bias_ext <<< FRAC_W);
`endif
        scaled = sum >>> FRAC_W;
        if (scaled > Z_MAX) begin
            sat = Z_MAX[DATA_W-1:0];
        end else if (scaled < Z_MIN) begin
            sat = Z_MIN[DATA_W-1:0];
        end else begin
            sat = scaled[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        z_valid_d = z_valid_q;
        z_value_d = z_value_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d  = prod_ext;
                    bias_d = bias;
                    cnt_d  = CNT_W'(1);
                    if (N_INPUTS == 1) begin
                        state_d = FINAL;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                z_value_d = sat;
                z_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (z_ready) begin
                    z_valid_d = 1'b0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready tracks the state being entered, so it stays low through reset.
        in_ready_d = (state_d == IDLE) || (state_d == ACC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            in_ready_q <= 1'b0;
            z_valid_q  <= 1'b0;
            z_value_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bias_q     <= bias_d;
            in_ready_q <= in_ready_d;
            z_valid_q  <= z_valid_d;
            z_value_q  <= z_value_d;
        end
    end

    assign in_ready = in_ready_q;
    assign z_valid  = z_valid_q;
    assign z_value  = z_value_q;
endmodule
